// File: rtl/lock_timing_ctrl.sv
// Timing and sequencing controller for the digital lock: prescaler tick,
// timed unlock window and timed lockout after repeated bad codes.
//
//  state       | meaning
//  ------------+-----------------------------------------------------------
//  ST_IDLE     | locked, attempts accepted, prescaler free-running
//  ST_UNLOCKED | lock open for UNLOCK_TICKS ticks or until relock
//  ST_LOCKOUT  | attempts refused for LOCKOUT_TICKS ticks
module lock_timing_ctrl #(
    parameter int TICK_DIV      = 200000,
    parameter int UNLOCK_TICKS  = 1250,
    parameter int LOCKOUT_TICKS = 7500,
    parameter int MAX_FAILS     = 3
) (
    input  logic                             clk_in,
    input  logic                             rst_n,
    input  logic                             attempt_valid,
    input  logic                             attempt_ok,
    input  logic                             relock,
    output logic                             attempt_ready,
    output logic                             unlocked,
    output logic                             lockout,
    output logic [$clog2(MAX_FAILS+1)-1:0]   fail_cnt,
    output logic                             tick
);

    localparam int MAX_TICKS = (UNLOCK_TICKS > LOCKOUT_TICKS) ? UNLOCK_TICKS : LOCKOUT_TICKS;
    localparam int TW        = $clog2(MAX_TICKS + 1);
    localparam int PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int FW        = $clog2(MAX_FAILS + 1);

    localparam logic [PW-1:0] PRESC_MAX    = PW'(TICK_DIV - 1);
    localparam logic [TW-1:0] UNLOCK_LOAD  = TW'(UNLOCK_TICKS);
    localparam logic [TW-1:0] LOCKOUT_LOAD = TW'(LOCKOUT_TICKS);
    localparam logic [TW-1:0] TIMER_LAST   = TW'(1);
    localparam logic [FW-1:0] FAIL_SAT     = FW'(MAX_FAILS);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_UNLOCKED = 2'd1,
        ST_LOCKOUT  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [FW-1:0]   fail_cnt_q, fail_cnt_d;
    logic            tick_q, tick_d;
    logic            unlocked_q, unlocked_d;
    logic            lockout_q, lockout_d;
    logic            attempt_ready_q, attempt_ready_d;
    logic            presc_wrap;
    logic            expire;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            presc_q         <= '0;
            timer_q         <= '0;
            fail_cnt_q      <= '0;
            tick_q          <= 1'b0;
            unlocked_q      <= 1'b0;
            lockout_q       <= 1'b0;
            attempt_ready_q <= 1'b1;
        end else begin
            state_q         <= state_d;
            presc_q         <= presc_d;
            timer_q         <= timer_d;
            fail_cnt_q      <= fail_cnt_d;
            tick_q          <= tick_d;
            unlocked_q      <= unlocked_d;
            lockout_q       <= lockout_d;
            attempt_ready_q <= attempt_ready_d;
        end
    end

    always_comb begin
        presc_wrap = (presc_q == PRESC_MAX);
        presc_d    = presc_wrap ? '0 : presc_q + 1'b1;
        tick_d     = presc_wrap;
        // Expiry is taken on the wrap edge itself, so the registered tick
        // pulse lands in the first cycle back in IDLE.
        expire     = presc_wrap && (timer_q == TIMER_LAST);
        timer_d    = timer_q;
        if (presc_wrap && (timer_q != '0)) begin
            timer_d = timer_q - 1'b1;
        end
        state_d    = state_q;
        fail_cnt_d = fail_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (attempt_valid) begin
                    if (attempt_ok) begin
                        state_d    = ST_UNLOCKED;
                        fail_cnt_d = '0;
                        presc_d    = '0;
                        timer_d    = UNLOCK_LOAD;
                    end else if ((int'(fail_cnt_q) + 1) >= MAX_FAILS) begin
                        state_d    = ST_LOCKOUT;
                        fail_cnt_d = FAIL_SAT;
                        presc_d    = '0;
                        timer_d    = LOCKOUT_LOAD;
                    end else begin
                        fail_cnt_d = fail_cnt_q + 1'b1;
                    end
                end
            end
            ST_UNLOCKED: begin
                if (relock || expire) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end
            end
            ST_LOCKOUT: begin
                if (expire) begin
                    state_d    = ST_IDLE;
                    fail_cnt_d = '0;
                    timer_d    = '0;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                fail_cnt_d = '0;
                timer_d    = '0;
            end
        endcase

        attempt_ready_d = (state_d == ST_IDLE);
        unlocked_d      = (state_d == ST_UNLOCKED);
        lockout_d       = (state_d == ST_LOCKOUT);
    end

    assign attempt_ready = attempt_ready_q;
    assign unlocked      = unlocked_q;
    assign lockout       = lockout_q;
    assign fail_cnt      = fail_cnt_q;
    assign tick          = tick_q;

endmodule

// File: tb/tb_lock_timing_ctrl.sv
// Bench for lock_timing_ctrl: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a cycle-count model.
module tb_lock_timing_ctrl;

    localparam int TD = 4;
    localparam int UT = 3;
    localparam int LT = 5;
    localparam int MF = 3;

    logic       clk_in = 1'b0;
    logic       rst_n  = 1'b0;
    logic       attempt_valid = 1'b0;
    logic       attempt_ok    = 1'b0;
    logic       relock        = 1'b0;
    logic       attempt_ready;
    logic       unlocked;
    logic       lockout;
    logic [1:0] fail_cnt;
    logic       tick;

    int n_cmp = 0;
    int n_err = 0;

    // model: mode 0 idle, 1 unlocked, 2 lockout; rem = clock cycles left in mode
    int m_mode, m_rem, m_phase, m_fail, m_tick;

    lock_timing_ctrl #(
        .TICK_DIV(TD), .UNLOCK_TICKS(UT), .LOCKOUT_TICKS(LT), .MAX_FAILS(MF)
    ) dut (
        .clk_in(clk_in),
        .rst_n(rst_n),
        .attempt_valid(attempt_valid),
        .attempt_ok(attempt_ok),
        .relock(relock),
        .attempt_ready(attempt_ready),
        .unlocked(unlocked),
        .lockout(lockout),
        .fail_cnt(fail_cnt),
        .tick(tick)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode  = 0;
        m_rem   = 0;
        m_phase = 0;
        m_fail  = 0;
        m_tick  = 0;
    endtask

    task automatic model_step(input bit v, input bit ok, input bit r);
        m_tick  = (m_phase == TD - 1) ? 1 : 0;
        m_phase = (m_phase + 1) % TD;
        case (m_mode)
            0: if (v) begin
                if (ok) begin
                    m_mode = 1; m_rem = UT * TD; m_fail = 0; m_phase = 0;
                end else if (m_fail + 1 >= MF) begin
                    m_mode = 2; m_rem = LT * TD; m_fail = MF; m_phase = 0;
                end else begin
                    m_fail = m_fail + 1;
                end
            end
            1: begin
                m_rem = m_rem - 1;
                if (r || m_rem == 0) m_mode = 0;
            end
            default: begin
                m_rem = m_rem - 1;
                if (m_rem == 0) begin
                    m_mode = 0; m_fail = 0;
                end
            end
        endcase
    endtask

    task automatic check_model();
        chk("ready",    int'(attempt_ready), (m_mode == 0) ? 1 : 0);
        chk("unlocked", int'(unlocked),      (m_mode == 1) ? 1 : 0);
        chk("lockout",  int'(lockout),       (m_mode == 2) ? 1 : 0);
        chk("fail_cnt", int'(fail_cnt),      m_fail);
        chk("tick",     int'(tick),          m_tick);
        chk("exclusive", int'(unlocked & lockout), 0);
    endtask

    // Called right after a falling edge; returns right after the next one.
    task automatic step(input bit v, input bit ok, input bit r);
        attempt_valid = v;
        attempt_ok    = ok;
        relock        = r;
        model_step(v, ok, r);
        @(negedge clk_in);
        check_model();
    endtask

    task automatic do_reset();
        attempt_valid = 1'b0;
        attempt_ok    = 1'b0;
        relock        = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_unlocked", int'(unlocked), 0);
        chk("rst_lockout",  int'(lockout), 0);
        chk("rst_fail_cnt", int'(fail_cnt), 0);
        chk("rst_tick",     int'(tick), 0);
        model_reset();
        @(negedge clk_in);
        @(negedge clk_in);
        rst_n = 1'b1;
        chk("rst_ready", int'(attempt_ready), 1);
    endtask

    initial begin
        int cnt_u, cnt_l, cnt_bad;
        logic [13:0] mask;
        model_reset();
        @(negedge clk_in);

        // reset asserted while unlocked
        do_reset();
        step(1, 1, 0);
        for (int k = 0; k < 3; k++) step(0, 0, 0);
        chk("t1_open", int'(unlocked), 1);
        do_reset();
        step(0, 0, 0);
        chk("t1_idle_after", int'(unlocked), 0);

        // correct code: 12-cycle window, ticks at fixed offsets
        do_reset();
        cnt_u = 0;
        mask  = '0;
        for (int k = 0; k < 14; k++) begin
            step(k == 0, k == 0, 0);
            if (k > 0 && tick) mask[k] = 1'b1;
            if (unlocked) cnt_u++;
        end
        chk("t2_unlock_len", cnt_u, 12);
        chk("t2_tick_pos", int'(mask), 'h1110);

        // three bad codes -> lockout, blocked attempts and relock inside it
        do_reset();
        step(1, 0, 0);
        chk("t3_fail1", int'(fail_cnt), 1);
        step(0, 0, 0); step(0, 0, 0);
        step(1, 0, 0);
        chk("t3_fail2", int'(fail_cnt), 2);
        step(0, 0, 0); step(0, 0, 0);
        step(1, 0, 0);
        chk("t3_fail3", int'(fail_cnt), 3);
        cnt_l = 1;
        cnt_bad = 0;
        for (int k = 1; k < 22; k++) begin
            step(k == 3 || k == 10 || k == 15, k == 3 || k == 15, k == 7 || k == 15);
            if (lockout) cnt_l++;
            if (unlocked) cnt_bad++;
            if (k == 20) begin
                chk("t3_exit_fail", int'(fail_cnt), 0);
                chk("t3_exit_ready", int'(attempt_ready), 1);
            end
        end
        chk("t3_lockout_len", cnt_l, 20);
        chk("t4_no_unlock", cnt_bad, 0);

        // early relock, then relock coincident with expiry
        do_reset();
        step(1, 1, 0);
        for (int k = 1; k < 5; k++) step(0, 0, 0);
        step(0, 0, 1);
        chk("t5_early_unl", int'(unlocked), 0);
        chk("t5_early_rdy", int'(attempt_ready), 1);
        step(1, 1, 0);
        for (int k = 1; k < 12; k++) step(0, 0, 0);
        chk("t5_last_open", int'(unlocked), 1);
        step(0, 0, 1);
        chk("t5_coinc_unl", int'(unlocked), 0);
        chk("t5_coinc_rdy", int'(attempt_ready), 1);
        step(0, 0, 1);
        chk("t5_stay_idle", int'(attempt_ready), 1);

        // fail counter cleared by a good code
        do_reset();
        step(1, 0, 0);
        step(1, 0, 0);
        chk("t6_fail2", int'(fail_cnt), 2);
        step(1, 1, 0);
        chk("t6_fail0", int'(fail_cnt), 0);
        chk("t6_open", int'(unlocked), 1);
        step(0, 0, 1);
        step(1, 0, 0);
        chk("t6_fail_again", int'(fail_cnt), 1);
        chk("t6_no_lockout", int'(lockout), 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                     $urandom_range(0, 9) == 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
